seg_stream_receiver: RTL

- Receive end of the serial 7-segment display link driven by the counter's shift-out stage.
- Takes one serial segment lane per digit plus the shared shift clock.
- Deserializes each lane, decodes each 7-bit segment pattern back to a 4-bit hex digit, and presents a validated parallel counter value.
- Used for on-chip loopback/self-check and by companion designs that mirror the counter display.

---
 rtl/seg_stream_receiver.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg_stream_receiver.sv
// Receive end of the serial 7-segment link: synchronizes the per-digit serial lanes
// and the shared shift clock, deserializes one frame per lane and decodes it to hex.
module seg_stream_receiver #(
  parameter int DIGITS   = 4,
  parameter int SEG_BITS = 7,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     ser_in,
  input  logic                  shift_clk_in,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     code_err,
  output logic                  frame_err
);

  localparam int BW = $clog2(SEG_BITS + 1);
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(SEG_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state;

  logic [DIGITS-1:0]   ser_s1, ser_s2;
  logic                sclk_s1, sclk_s2, sclk_s3;
  logic                shift_edge;
  logic [BW-1:0]       bit_cnt;
  logic [IW-1:0]       idle_cnt;
  logic [SEG_BITS-1:0] shift_reg [DIGITS];
  logic [4*DIGITS-1:0] dec_digits;
  logic [DIGITS-1:0]   dec_err;

  // Returns {err, value}; a pattern outside the hex font flags err with value 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'b1111110: res = 5'h00;
      7'b0110000: res = 5'h01;
      7'b1101101: res = 5'h02;
      7'b1111001: res = 5'h03;
      7'b0110011: res = 5'h04;
      7'b1011011: res = 5'h05;
      7'b1011111: res = 5'h06;
      7'b1110000: res = 5'h07;
      7'b1111111: res = 5'h08;
      7'b1111011: res = 5'h09;
      7'b1110111: res = 5'h0a;
      7'b0011111: res = 5'h0b;
      7'b1001110: res = 5'h0c;
      7'b0111101: res = 5'h0d;
      7'b1001111: res = 5'h0e;
      7'b1000111: res = 5'h0f;
      default:    res = 5'h10;
    endcase
    return res;
  endfunction

  // Data and clock share the same two-flop depth, so the synced data is aligned
  // with the edge pulse derived from the third clock flop.
  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which keeps the chain intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_s1  <= '0;
      ser_s2  <= '0;
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
    end else begin
      ser_s1  <= ser_in;
      ser_s2  <= ser_s1;
      sclk_s1 <= shift_clk_in;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
    end
  end

  assign shift_edge = sclk_s2 & ~sclk_s3;

  // NOTE: every variable driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    dec_digits = '0;
    dec_err    = '0;
    for (int j = 0; j < DIGITS; j++) begin
      {dec_err[j], dec_digits[4*j +: 4]} = decode_seg(shift_reg[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      digits_out  <= '0;
      code_err    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      // NOTE: the shift registers are small and must restart from a known frame,
      // so unlike a RAM they are explicitly cleared on reset.
      for (int j = 0; j < DIGITS; j++) shift_reg[j] <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          if (shift_edge) begin
            for (int j = 0; j < DIGITS; j++)
              shift_reg[j] <= {shift_reg[j][SEG_BITS-2:0], ser_s2[j]};
            bit_cnt <= BW'(1);
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (shift_edge) begin
            for (int j = 0; j < DIGITS; j++)
              shift_reg[j] <= {shift_reg[j][SEG_BITS-2:0], ser_s2[j]};
            bit_cnt  <= bit_cnt + 1'b1;
            idle_cnt <= '0;
            if (bit_cnt == LAST_BIT) state <= DONE;
          end else if (idle_cnt == IDLE_MAX) begin
            // Stalled partial frame: drop it, keep the last good digits.
            frame_err <= 1'b1;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            for (int j = 0; j < DIGITS; j++) shift_reg[j] <= '0;
            state <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        DONE: begin
          digits_out  <= dec_digits;
          code_err    <= dec_err;
          frame_valid <= 1'b1;
          idle_cnt    <= '0;
          // An edge arriving here is bit 1 of the next frame.
          if (shift_edge) begin
            for (int j = 0; j < DIGITS; j++)
              shift_reg[j] <= {shift_reg[j][SEG_BITS-2:0], ser_s2[j]};
            bit_cnt <= BW'(1);
            state   <= SHIFT;
          end else begin
            bit_cnt <= '0;
            state   <= IDLE;
          end
        end

        default: begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
